// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer slice.
//   DW          : ALU data width
//   OP_*        : 3-bit ALU opcodes
//   seq_state_t : sequencer FSM encoding (IDLE/EXEC/WB)
//   seq_op_t    : one buffered operation, {op, data}
package alu_pkg;

   localparam int DW  = 8;
   localparam int OPW = 3;

   localparam logic [OPW-1:0] OP_PASS = 3'b000;   // accum unchanged
   localparam logic [OPW-1:0] OP_ADD  = 3'b001;
   localparam logic [OPW-1:0] OP_SUB  = 3'b010;   // accum - data
   localparam logic [OPW-1:0] OP_AND  = 3'b011;
   localparam logic [OPW-1:0] OP_OR   = 3'b100;
   localparam logic [OPW-1:0] OP_XOR  = 3'b101;
   localparam logic [OPW-1:0] OP_LOAD = 3'b110;   // accum <= data
   localparam logic [OPW-1:0] OP_NOT  = 3'b111;   // ~accum

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WB   = 2'd2
   } seq_state_t;

   typedef struct packed {
      logic [OPW-1:0] op;
      logic [DW-1:0]  data;
   } seq_op_t;

endpackage

// File: rtl/alu_seq_fifo.sv
// Synchronous FIFO holding pending ALU operations.
//   clk, rst      : clock, async active-high reset (pointers/count only)
//   push, pop     : write / read strobes; ignored when full / empty
//   wr_data       : entry to write
//   rd_data       : head entry (valid while !empty)
//   full, empty   : occupancy flags
//   count         : number of stored entries, AW+1 bits
module alu_seq_fifo #(
   parameter int DEPTH = 4,
   parameter int AW    = 2,
   parameter int W     = 11
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  wr_data,
   output logic [W-1:0]  rd_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   // Storage carries no reset; entries are only read once written.
   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= wr_data;
   end

   // Pointers wrap naturally at DEPTH since DEPTH == 2**AW.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)
            rd_ptr <= rd_ptr + 1'b1;
         unique case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Sequencer in front of the 8-bit ALU: buffers operations, presents
// opcode/data/accum to the ALU from registers and captures alu_out
// back into the accumulator.
//   clk, rst            : clock, async active-high reset
//   in_valid/in_ready   : operation handshake (in_op, in_data)
//   acc_clr             : synchronous accumulator clear, beats capture
//   opcode, data, accum : registered ALU inputs
//   alu_out             : combinational ALU result
//   res_valid           : one-cycle pulse, accum just updated
//   busy                : work pending or in flight
//   op_count            : completed-op counter, saturating (only with
//                         ALU_SEQ_OPCNT_EN defined)
//
// state | meaning
// IDLE  | nothing in flight; pop head when FIFO non-empty
// EXEC  | ALU inputs stable; capture alu_out on the next edge
// WB    | res_valid high; pop next op or return to IDLE
module alu_seq
   import alu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [OPW-1:0] in_op,
   input  logic [DW-1:0]  in_data,
   input  logic           acc_clr,
   output logic [OPW-1:0] opcode,
   output logic [DW-1:0]  data,
   output logic [DW-1:0]  accum,
   input  logic [DW-1:0]  alu_out,
   output logic           res_valid,
   output logic           busy
`ifdef ALU_SEQ_OPCNT_EN
   ,
   output logic [15:0]    op_count
`endif
);

   seq_state_t state;
   seq_op_t    head;
   seq_op_t    entry;
   logic       fifo_full;
   logic       fifo_empty;
   logic [AW:0] fifo_count;
   logic       push;
   logic       pop;

   assign entry    = '{op: in_op, data: in_data};
   assign in_ready = !fifo_full;
   assign push     = in_valid && in_ready;
   // Pop only from IDLE or WB; a push landing this edge is not visible
   // until the next cycle because empty is count-based.
   assign pop      = !fifo_empty && ((state == ST_IDLE) || (state == ST_WB));
   assign busy     = (fifo_count != '0) || (state != ST_IDLE);

   alu_seq_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .W     ($bits(seq_op_t))
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .pop     (pop),
      .wr_data (entry),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         opcode    <= '0;
         data      <= '0;
         accum     <= '0;
         res_valid <= 1'b0;
      end else begin
         res_valid <= 1'b0;

         if (acc_clr)
            accum <= '0;
         else if (state == ST_EXEC)
            accum <= alu_out;

         unique case (state)
            ST_IDLE, ST_WB: begin
               if (pop) begin
                  opcode <= head.op;
                  data   <= head.data;
                  state  <= ST_EXEC;
               end else begin
                  state  <= ST_IDLE;
               end
            end
            ST_EXEC: begin
               state     <= ST_WB;
               res_valid <= 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef ALU_SEQ_OPCNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         op_count <= '0;
      else if ((state == ST_WB) && (op_count != 16'hFFFF))
         op_count <= op_count + 1'b1;
   end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq. A behavioural ALU drives alu_out; a
// transaction-level model (queue of accepted ops + running accumulator)
// predicts accum at every res_valid pulse. Directed sections cover
// latency, streaming, full boundary, acc_clr collision and reset.
module tb_alu_seq;
   import alu_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_op;
   logic [7:0] in_data;
   logic       acc_clr;
   logic [2:0] opcode;
   logic [7:0] data;
   logic [7:0] accum;
   logic [7:0] alu_out;
   logic       res_valid;
   logic       busy;
`ifdef ALU_SEQ_OPCNT_EN
   logic [15:0] op_count;
`endif

   int n_chk = 0;
   int n_err = 0;
   int n_push = 0;
   int n_res = 0;

   typedef struct { logic [2:0] op; logic [7:0] d; } tb_op_t;
   tb_op_t     q[$];
   logic [7:0] acc_model = 8'h00;
   logic       clr_prev = 1'b0;

   always #5 clk = ~clk;

   alu_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_data   (in_data),
      .acc_clr   (acc_clr),
      .opcode    (opcode),
      .data      (data),
      .accum     (accum),
      .alu_out   (alu_out),
      .res_valid (res_valid),
      .busy      (busy)
`ifdef ALU_SEQ_OPCNT_EN
      ,
      .op_count  (op_count)
`endif
   );

   function automatic logic [7:0] ref_alu(input logic [2:0] op, input logic [7:0] d, input logic [7:0] a);
      case (op)
         OP_PASS: return a;
         OP_ADD:  return 8'((int'(a) + int'(d)) % 256);
         OP_SUB:  return 8'((int'(a) - int'(d) + 256) % 256);
         OP_AND:  return a & d;
         OP_OR:   return a | d;
         OP_XOR:  return a ^ d;
         OP_LOAD: return d;
         default: return ~a;
      endcase
   endfunction

   always_comb alu_out = ref_alu(opcode, data, accum);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Transaction model, sampled mid-cycle. A clear seen in the cycle
   // before a result means that result was overwritten by the clear.
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         acc_model = 8'h00;
         clr_prev  = 1'b0;
      end else begin
         if (res_valid) begin
            n_res++;
            if (q.size() == 0) begin
               chk("res_without_op", 1, 0);
            end else begin
               tb_op_t e;
               e = q.pop_front();
               if (clr_prev) acc_model = 8'h00;
               else          acc_model = ref_alu(e.op, e.d, acc_model);
               chk("res_accum", accum, acc_model);
            end
         end else if (clr_prev) begin
            acc_model = 8'h00;
         end
         if (in_valid && in_ready) begin
            q.push_back('{op: in_op, d: in_data});
            n_push++;
         end
         clr_prev = acc_clr;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 60) begin
         tick();
         n++;
      end
      if (busy) chk("idle_timeout", 1, 0);
   endtask

   task automatic push_one(input logic [2:0] op, input logic [7:0] d);
      int n = 0;
      in_valid = 1'b1; in_op = op; in_data = d;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      int pushed, pulses, last, accepted, res0;
      rst = 1'b1; in_valid = 1'b0; in_op = '0; in_data = '0; acc_clr = 1'b0;
      tick(); tick();
      chk("rst_opcode", opcode, 0);
      chk("rst_data", data, 0);
      chk("rst_accum", accum, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      tick();

      // single-op latency
      in_valid = 1'b1; in_op = OP_ADD; in_data = 8'h05;
      tick();
      in_valid = 1'b0;
      chk("lat_no_bypass", opcode, 0);
      chk("lat_busy", busy, 1);
      tick();
      chk("lat_pop_op", opcode, 3'b001);
      chk("lat_pop_data", data, 8'h05);
      chk("lat_res_early", res_valid, 0);
      tick();
      chk("lat_accum", accum, 8'h05);
      chk("lat_res", res_valid, 1);
      tick();
      chk("lat_res_pulse", res_valid, 0);
      chk("lat_idle", busy, 0);

      // back-to-back stream of ADD 0x40
      acc_clr = 1'b1; tick(); acc_clr = 1'b0;
      chk("clr_idle", accum, 0);
      pushed = 0; pulses = 0; last = -1;
      for (int cyc = 0; cyc < 40 && pulses < 5; cyc++) begin
         in_valid = (pushed < 5); in_op = OP_ADD; in_data = 8'h40;
         if (in_valid && in_ready) pushed++;
         tick();
         if (res_valid) begin
            if (last >= 0) chk("stream_gap", cyc - last, 2);
            last = cyc;
            pulses++;
         end
      end
      in_valid = 1'b0;
      chk("stream_pulses", pulses, 5);
      chk("stream_accum", accum, 8'h40);
      wait_idle();

      // full boundary: 7 pushes from idle fill the FIFO at a WB cycle
      accepted = 0;
      in_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         in_op = 3'($urandom_range(0, 7)); in_data = 8'($urandom);
         if (in_ready) accepted++;
         tick();
      end
      chk("full_accepted", accepted, 7);
      chk("full_ready", in_ready, 0);
      in_op = OP_XOR; in_data = 8'($urandom);
      tick();
      chk("full_pop_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      wait_idle();
      chk("full_drain", n_res, n_push);

      // acc_clr colliding with EXEC capture
      in_valid = 1'b1; in_op = OP_LOAD; in_data = 8'h21;
      tick();
      in_valid = 1'b0;
      wait_idle();
      in_valid = 1'b1; in_op = OP_ADD; in_data = 8'h33;
      tick();
      in_valid = 1'b0;
      tick();
      acc_clr = 1'b1;
      tick();
      acc_clr = 1'b0;
      chk("clr_accum", accum, 0);
      chk("clr_res", res_valid, 1);
      push_one(OP_ADD, 8'h07);
      wait_idle();
      chk("clr_next_op", accum, 8'h07);

      // random traffic with occasional clears
      for (int i = 0; i < 300; i++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_op    = 3'($urandom_range(0, 7));
         in_data  = 8'($urandom);
         acc_clr  = ($urandom_range(0, 15) == 0);
         tick();
      end
      in_valid = 1'b0; acc_clr = 1'b0;
      wait_idle();
      chk("rand_drain", n_res, n_push);

      // reset during EXEC of the first of several queued ops
      push_one(OP_LOAD, 8'h5A);
      wait_idle();
      chk("pre_rst_accum", accum, 8'h5A);
      in_valid = 1'b1; in_op = OP_ADD; in_data = 8'h11;
      tick(); tick();
      rst = 1'b1;
      #1;
      chk("mid_rst_accum", accum, 0);
      chk("mid_rst_res", res_valid, 0);
      chk("mid_rst_ready", in_ready, 1);
      chk("mid_rst_busy", busy, 0);
      in_valid = 1'b0;
      tick();
      rst = 1'b0;
      res0 = n_res;
      for (int i = 0; i < 8; i++) tick();
      chk("post_rst_quiet", n_res - res0, 0);
      chk("post_rst_busy", busy, 0);

`ifdef ALU_SEQ_OPCNT_EN
      chk("opcnt_reset", op_count, 0);
      for (int i = 0; i < 3; i++) push_one(OP_LOAD, 8'(i));
      wait_idle();
      chk("opcnt_three", op_count, 3);
      force dut.op_count = 16'hFFFD;
      tick();
      release dut.op_count;
      for (int i = 0; i < 3; i++) push_one(OP_ADD, 8'h01);
      wait_idle();
      chk("opcnt_sat", op_count, 16'hFFFF);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
